xge_pkt_rx_source: RTL
======================

// Module: xge_pkt_rx_source
// PURPOSE
//  Frame-buffered source for the MAC packet-receive interface (pkt_rx_*). Upstream logic
//  writes 64-bit frame words; the block stores them and presents complete frames to the
//  host with the pkt_rx_avail / pkt_rx_ren / pkt_rx_val read protocol. It is the sending
//  end of the interface the test harness drives pkt_rx_ren into and samples pkt_rx_* from.
// PARAMETERS
//  DEPTH_LOG2  6  log2 of buffer depth in words (64 words)
//  FRM_CNT_W   7  width of complete-frame counter; must be >= DEPTH_LOG2+1
// PORTS
//  clk_156m25      in   1   single clock, all logic on posedge
//  reset_156m25_n  in   1   asynchronous, active-low reset
//  wr_en           in   1   upstream word write strobe
//  wr_data         in   64  word data, byte 0 in [7:0]
//  wr_sop          in   1   first word of frame
//  wr_eop          in   1   last word of frame
//  wr_mod          in   3   valid bytes on eop word, 0 = all 8
//  wr_err          in   1   frame error, meaningful on eop word
//  wr_full         out  1   buffer full; writes this cycle are dropped
//  ovf             out  1   sticky: a write was dropped; cleared only by reset
//  pkt_rx_ren      in   1   host read enable
//  pkt_rx_avail    out  1   at least one complete frame buffered
//  pkt_rx_val      out  1   pkt_rx_data/sop/eop/mod/err valid this cycle
//  pkt_rx_data     out  64  read word
//  pkt_rx_sop      out  1   read word is start of frame
//  pkt_rx_eop      out  1   read word is end of frame
//  pkt_rx_mod      out  3   valid bytes on eop word, 0 = all 8
//  pkt_rx_err      out  1   frame error, qualified by pkt_rx_eop
// BEHAVIOUR
//  - Reset: all outputs 0, buffer empty, frame count 0, ovf 0. Reset mid-frame discards
//    all contents, including partial frames; no word is emitted afterwards.
//  - Write accept: wr_en && !wr_full pushes {data,sop,eop,mod,err}.
//    wr_en && wr_full drops the word and sets ovf. The upstream side is responsible for
//    framing; the block does not check sop/eop ordering.
//  - wr_full is registered: asserts when occupancy == 2**DEPTH_LOG2.
//  - Frame count increments on an accepted eop write and decrements on an eop pop.
//    With both in the same cycle it is unchanged. Never wraps: writes are bounded by depth.
//  - pkt_rx_avail is a register equal to (frame count != 0) after this cycle's update.
//  - Pop condition: pkt_rx_ren && (frame count != 0) && !empty. Reads never enter an
//    incomplete frame.
//  - Read latency is 1: a pop in cycle N drives pkt_rx_val=1 and the word fields in
//    cycle N+1. With no pop, pkt_rx_val=0 and the data fields hold their last value.
//  - pkt_rx_ren with no complete frame is ignored; pkt_rx_val stays 0.
//  - The host may hold pkt_rx_ren across frame boundaries: the next frame's sop follows
//    the previous eop with no bubble if that frame is complete.
//  - Popping the last buffered eop drops pkt_rx_avail in the same cycle that
//    pkt_rx_val/pkt_rx_eop are shown.
//  - Simultaneous push and pop while full is legal: the pop frees a slot, but wr_full is
//    registered, so the push is still dropped if wr_full=1 that cycle.
// STRUCTURE
//  - Package xge_pkt_pkg: typedef struct packed pkt_word_t {data[63:0], sop, eop,
//    mod[2:0], err} (70 bits), plus constant PKT_MOD_FULL = 3'd0.
//  - Sub-module xge_sync_fifo #(WIDTH, DEPTH_LOG2): single-clock FIFO with registered
//    full/empty, registered read output, wrap-around pointers and an extra MSB for
//    full/empty disambiguation.
//  - Top level holds the frame counter, ovf, the pop/valid pipeline and the output
//    registers.
// TESTING
//  1. Write 3-word frame (sop, mid, eop mod=5, data 0x11..,0x22..,0x33..), then ren=1
//     -> avail=1 after the eop write; val on 3 consecutive cycles with sop, -, eop
//     mod=5; avail=0 with the eop word.
//  2. Write 2 frames back-to-back, hold ren=1 -> 5 contiguous val cycles; the eop of
//     frame 1 is immediately followed by the sop of frame 2; avail stays 1 until the
//     last eop.
//  3. Write 64 words with no eop, then write 1 more -> wr_full=1, extra word dropped,
//     ovf=1; ren=1 -> val stays 0 because avail=0.
//  4. One frame buffered, reading its eop in the same cycle as a new frame's eop write
//     -> frame count unchanged, avail stays 1, new frame readable next.
//  5. Assert reset_156m25_n=0 mid-read of a 4-word frame -> outputs 0 asynchronously;
//     after release avail=0, ren yields no val.
//  6. Frame with wr_err=1 on eop -> pkt_rx_err=1 only on the eop output word.

Source files
------------

// File: rtl/xge_pkt_pkg.sv
// Shared types for the packet-receive source: one buffered frame word and its flags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xge_pkt_pkg;

    // One stored frame word: 64 data bits plus framing flags (70 bits total).
    typedef struct packed {
        logic [63:0] data;  // byte 0 in [7:0]
        logic        sop;   // first word of frame
        logic        eop;   // last word of frame
        logic [2:0]  mod;   // valid bytes on eop word, PKT_MOD_FULL = all 8
        logic        err;   // frame error, meaningful on eop word
    } pkt_word_t;

    localparam int          PKT_WORD_W   = $bits(pkt_word_t);
    localparam logic [2:0]  PKT_MOD_FULL = 3'd0;

endpackage

// File: rtl/xge_pkt_rx_source_if.sv
// Bundles the upstream write port and the host pkt_rx_* read port of the frame source.
// Latency: n/a (wiring only).
// Backpressure: wr_full on the write side, pkt_rx_avail/pkt_rx_ren on the read side.
//
// Signals
//   wr_en/wr_data/wr_sop/wr_eop/wr_mod/wr_err  upstream word write
//   wr_full, ovf                               write-side status
//   pkt_rx_ren                                 host read enable
//   pkt_rx_avail/val/data/sop/eop/mod/err      host read side
// Modports
//   master : the frame source itself (drives status and pkt_rx_* outputs)
//   slave  : upstream writer plus host reader
interface xge_pkt_rx_source_if;

    logic        wr_en;
    logic [63:0] wr_data;
    logic        wr_sop;
    logic        wr_eop;
    logic [2:0]  wr_mod;
    logic        wr_err;
    logic        wr_full;
    logic        ovf;

    logic        pkt_rx_ren;
    logic        pkt_rx_avail;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;

    modport master (
        input  wr_en, wr_data, wr_sop, wr_eop, wr_mod, wr_err, pkt_rx_ren,
        output wr_full, ovf, pkt_rx_avail, pkt_rx_val, pkt_rx_data,
               pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err
    );

    modport slave (
        output wr_en, wr_data, wr_sop, wr_eop, wr_mod, wr_err, pkt_rx_ren,
        input  wr_full, ovf, pkt_rx_avail, pkt_rx_val, pkt_rx_data,
               pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err
    );

endinterface

// File: rtl/xge_sync_fifo.sv
// Single-clock FIFO with registered full/empty and a registered read-data port.
// Latency: write visible to a read one cycle later; read data appears the cycle after rd_en.
// Backpressure: writes while full_o=1 and reads while empty_o=1 are ignored.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en_i, wr_data_i    push request and data
//   full_o                registered: occupancy == 2**DEPTH_LOG2
//   rd_en_i               pop request
//   rd_head_o             combinational view of the word at the read pointer
//   rd_data_o             registered popped word; holds when no pop
//   empty_o               registered: occupancy == 0
module xge_sync_fifo #(
    parameter int WIDTH      = 70,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_head_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra MSB so that equal addresses can be told apart
    // as either empty (MSBs equal) or full (MSBs differ).
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             push, pop;

    always_comb begin
        push     = wr_en_i && !full_q;
        pop      = rd_en_i && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (pop) begin
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign rd_head_o = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/xge_pkt_rx_source.sv
// Frame-buffered pkt_rx_* source: stores upstream words, releases only complete frames.
// Latency: one cycle from an accepted pkt_rx_ren to pkt_rx_val with the word fields.
// Backpressure: registered wr_full drops writes (sticky ovf); reads wait for pkt_rx_avail.
//
// Ports
//   clk_156m25       single clock, all logic on posedge
//   reset_156m25_n   asynchronous active-low reset, discards all buffered words
//   rx_if            write port, status and host read port (master modport)
module xge_pkt_rx_source
    import xge_pkt_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int FRM_CNT_W  = 7    // must hold 2**DEPTH_LOG2 frames: >= DEPTH_LOG2+1
) (
    input  logic                 clk_156m25,
    input  logic                 reset_156m25_n,
    xge_pkt_rx_source_if.master  rx_if
);

    localparam logic [FRM_CNT_W-1:0] CNT_ONE = {{(FRM_CNT_W-1){1'b0}}, 1'b1};

    pkt_word_t              wr_word;
    pkt_word_t              head_word;
    pkt_word_t              rd_word;
    logic [PKT_WORD_W-1:0]  fifo_head;
    logic [PKT_WORD_W-1:0]  fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic [FRM_CNT_W-1:0]   frm_cnt_q, frm_cnt_d;
    logic                   avail_q, avail_d;
    logic                   ovf_q, ovf_d;
    logic                   val_q;
    logic                   push_acc;
    logic                   pop;
    logic                   frm_in;
    logic                   frm_out;
    logic                   unused_head;

    assign wr_word = {rx_if.wr_data, rx_if.wr_sop, rx_if.wr_eop, rx_if.wr_mod, rx_if.wr_err};

    xge_sync_fifo #(
        .WIDTH      (PKT_WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk_156m25),
        .rst_n     (reset_156m25_n),
        .wr_en_i   (rx_if.wr_en),
        .wr_data_i (wr_word),
        .full_o    (fifo_full),
        .rd_en_i   (pop),
        .rd_head_o (fifo_head),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty)
    );

    assign head_word = fifo_head;
    assign rd_word   = fifo_rd_data;

    // Only the eop flag of the head word matters here; the rest arrives via rd_data.
    assign unused_head = ^{head_word.data, head_word.sop, head_word.mod, head_word.err};

    always_comb begin
        push_acc = rx_if.wr_en && !fifo_full;
        // A nonzero frame count guarantees a complete frame sits at or behind the
        // head, so a read can never run into a frame still being written.
        pop      = rx_if.pkt_rx_ren && (frm_cnt_q != '0) && !fifo_empty;
        frm_in   = push_acc && rx_if.wr_eop;
        frm_out  = pop && head_word.eop;

        frm_cnt_d = frm_cnt_q;
        case ({frm_in, frm_out})
            2'b10:   frm_cnt_d = frm_cnt_q + CNT_ONE;
            2'b01:   frm_cnt_d = frm_cnt_q - CNT_ONE;
            default: frm_cnt_d = frm_cnt_q;
        endcase

        // avail follows the updated count so the last eop pop lowers it
        // in the same cycle that word is presented.
        avail_d = (frm_cnt_d != '0);
        ovf_d   = ovf_q || (rx_if.wr_en && fifo_full);
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            frm_cnt_q <= '0;
            avail_q   <= 1'b0;
            ovf_q     <= 1'b0;
            val_q     <= 1'b0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            avail_q   <= avail_d;
            ovf_q     <= ovf_d;
            val_q     <= pop;
        end
    end

    assign rx_if.wr_full      = fifo_full;
    assign rx_if.ovf          = ovf_q;
    assign rx_if.pkt_rx_avail = avail_q;
    assign rx_if.pkt_rx_val   = val_q;
    assign rx_if.pkt_rx_data  = rd_word.data;
    assign rx_if.pkt_rx_sop   = rd_word.sop;
    assign rx_if.pkt_rx_eop   = rd_word.eop;
    assign rx_if.pkt_rx_mod   = rd_word.mod;
    assign rx_if.pkt_rx_err   = rd_word.err;

endmodule
